// File: rtl/audio_out_pkg.sv
// Shared widths and constants for the audio PWM output path.
// Offset-binary helper used where the scaled sample enters the PWM core.
package audio_out_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PWM_W    = 10;
  localparam int VOL_W    = 4;
  localparam int ERR_W    = SAMPLE_W - PWM_W;
  localparam int PROD_W   = SAMPLE_W + VOL_W + 1;

  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  function automatic logic [SAMPLE_W-1:0] to_offset(
    input logic [SAMPLE_W-1:0] s
  );
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/audio_pwm_out_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse.
// Pulse is one clk_i cycle per synchronised rising edge.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Both terms are flop outputs, so the pulse is glitch-free.
  assign pulse_o = s2_q & ~prev_q;

endmodule

// File: rtl/audio_pwm_out.sv
// Audio output stage: sample capture, volume scaling and
// error-feedback PWM on the board audio pin.
module audio_pwm_out
  import audio_out_pkg::*;
(
  input  logic                clk100,
  input  logic                reset,
  input  logic                sample_clk,
  input  logic [SAMPLE_W-1:0] audio_in,
  input  logic [VOL_W-1:0]    volume,
  input  logic                mute,
  output logic                aud_pwm,
  output logic                aud_sd,
  output logic                sample_strobe,
  output logic [PWM_W-1:0]    duty_dbg
);

  logic                       strobe;
  logic signed [SAMPLE_W-1:0] s_reg_q;
  logic signed [SAMPLE_W-1:0] scaled_q;
  logic [SAMPLE_W-1:0]        sample_u_q;
  logic                       v1_q;
  logic                       v2_q;
  logic [PWM_W-1:0]           cnt_q;
  logic [PWM_W-1:0]           duty_q;
  logic [ERR_W-1:0]           err_q;
  logic                       aud_pwm_q;
  logic                       aud_sd_q;

  logic [VOL_W:0]             gain;
  logic signed [PROD_W-1:0]   s_ext;
  logic signed [PROD_W-1:0]   g_ext;
  logic signed [PROD_W-1:0]   prod;
  logic [SAMPLE_W-1:0]        scaled_d;
  logic [SAMPLE_W:0]          sum;
  logic                       unused_prod;

  sync_edge u_sync (
    .clk_i   (clk100),
    .rst_i   (reset),
    .async_i (sample_clk),
    .pulse_o (strobe)
  );

  assign gain  = {1'b0, volume} + (VOL_W+1)'(1);
  assign s_ext = $signed({{(PROD_W-SAMPLE_W){s_reg_q[SAMPLE_W-1]}},
                          s_reg_q});
  assign g_ext = $signed({{(PROD_W-VOL_W-1){1'b0}}, gain});
  assign prod  = s_ext * g_ext;

  // Gain is at most 16, so the >>>4 result always fits the sample width.
  assign scaled_d    = prod[SAMPLE_W+VOL_W-1:VOL_W];
  assign unused_prod = ^{prod[PROD_W-1], prod[VOL_W-1:0]};

  assign sum = {1'b0, sample_u_q}
             + {{(SAMPLE_W+1-ERR_W){1'b0}}, err_q};

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      s_reg_q    <= '0;
      scaled_q   <= '0;
      sample_u_q <= MIDSCALE;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
    end else begin
      v1_q <= strobe;
      v2_q <= v1_q;
      if (strobe) begin
        s_reg_q <= audio_in;
      end
      if (v1_q) begin
        scaled_q <= scaled_d;
      end
      if (v2_q) begin
        sample_u_q <= mute ? MIDSCALE : to_offset(scaled_q);
      end
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      duty_q    <= '0;
      err_q     <= '0;
      aud_pwm_q <= 1'b0;
      aud_sd_q  <= 1'b0;
    end else begin
      aud_sd_q  <= 1'b1;
      cnt_q     <= cnt_q + PWM_W'(1);
      aud_pwm_q <= (cnt_q < duty_q);
      // Duty and residue only move at the period boundary.
      if (cnt_q == '1) begin
        if (sum[SAMPLE_W]) begin
          duty_q <= '1;
          err_q  <= '0;
        end else begin
          duty_q <= sum[SAMPLE_W-1:ERR_W];
          err_q  <= sum[ERR_W-1:0];
        end
      end
    end
  end

  assign aud_pwm       = aud_pwm_q;
  assign aud_sd        = aud_sd_q;
  assign sample_strobe = strobe;
  assign duty_dbg      = duty_q;

endmodule
